button_conditioner: RTL and testbench

Conditions the three raw push-button inputs of the breakout game before they reach the game top level's `btn_left`, `btn_right` and `btn_select` inputs. It provides a 2-flop synchroniser, a tick-based debouncer and registered press pulses, plus auto-repeat on left/right. It sits between the board pins and the game top level, upstream of the game logic.

---
 rtl/button_conditioner.sv | 177 +++++++++++++++++
 tb/tb_button_conditioner.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Synchroniser, tick debouncer and press-pulse generator for the three game buttons.
// Define BUTTON_AUTOREPEAT_EN to build the left/right auto-repeat FSMs.
module button_conditioner #(
    parameter int TICK_DIV       = 25000,
    parameter int DEBOUNCE_TICKS = 5,
    parameter int REPEAT_DELAY   = 300,
    parameter int REPEAT_RATE    = 60,
    parameter bit ACTIVE_LOW     = 1'b0
) (
    input  logic clk,
    input  logic nRst,
    input  logic en,
    input  logic raw_left,
    input  logic raw_right,
    input  logic raw_select,
    output logic btn_left,
    output logic btn_right,
    output logic btn_select,
    output logic left_pulse,
    output logic right_pulse,
    output logic select_pulse
);

    localparam int             TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [3:0]     DB_LAST   = 4'(DEBOUNCE_TICKS);
    localparam logic [2:0]     RELEASED  = ACTIVE_LOW ? 3'b111 : 3'b000;

    if (TICK_DIV < 2 || DEBOUNCE_TICKS < 1 || DEBOUNCE_TICKS > 15 ||
        REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
        $error("button_conditioner: parameter out of range");
    end

    // Bit order everywhere: [0]=left, [1]=right, [2]=select
    logic [2:0]      raw_vec;
    logic [2:0]      sync1_q, sync2_q, sync_val;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic            tick;
    logic [2:0]      stable_q, stable_d;
    logic [2:0][3:0] cnt_q, cnt_d;
    logic [2:0]      rise;
    logic [2:0]      rep_pulse;
    logic [2:0]      pulse_q, pulse_d;

    assign raw_vec  = {raw_select, raw_right, raw_left};
    assign sync_val = sync2_q ^ RELEASED;

    always_comb begin
        tick       = en && (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick_cnt_q;
        if (en) begin
            tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        end

        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int unsigned i = 0; i < 3; i++) begin
            if (en) begin
                if (sync_val[i] == stable_q[i]) begin
                    cnt_d[i] = '0;
                end else if (tick) begin
                    if (cnt_q[i] + 4'd1 == DB_LAST) begin
                        stable_d[i] = ~stable_q[i];
                        cnt_d[i]    = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 4'd1;
                    end
                end
            end
        end

        rise    = stable_d & ~stable_q;
        pulse_d = en ? (rise | rep_pulse) : '0;
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            sync1_q    <= RELEASED;
            sync2_q    <= RELEASED;
            tick_cnt_q <= '0;
            stable_q   <= '0;
            cnt_q      <= '0;
            pulse_q    <= '0;
        end else begin
            sync1_q    <= raw_vec;
            sync2_q    <= sync1_q;
            tick_cnt_q <= tick_cnt_d;
            stable_q   <= stable_d;
            cnt_q      <= cnt_d;
            pulse_q    <= pulse_d;
        end
    end

`ifdef BUTTON_AUTOREPEAT_EN
    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_e;

    localparam logic [9:0] RD = 10'(REPEAT_DELAY);
    localparam logic [9:0] RR = 10'(REPEAT_RATE);

    rep_state_e      rep_state_q [2];
    rep_state_e      rep_state_d [2];
    logic [1:0][9:0] rc_q, rc_d;
    logic [1:0]      rep_fire;

    // FSMs see the next stable value so a release exits and a press enters on the same edge
    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            rep_state_d[i] = rep_state_q[i];
            rc_d[i]        = rc_q[i];
            rep_fire[i]    = 1'b0;
            if (!stable_d[i]) begin
                rep_state_d[i] = IDLE;
                rc_d[i]        = '0;
            end else if (en) begin
                case (rep_state_q[i])
                    IDLE: begin
                        if (rise[i]) begin
                            rep_state_d[i] = DELAY;
                            rc_d[i]        = '0;
                        end
                    end
                    DELAY: begin
                        if (tick) begin
                            if (rc_q[i] + 10'd1 == RD) begin
                                rep_fire[i]    = 1'b1;
                                rc_d[i]        = '0;
                                rep_state_d[i] = REPEAT;
                            end else begin
                                rc_d[i] = rc_q[i] + 10'd1;
                            end
                        end
                    end
                    REPEAT: begin
                        if (tick) begin
                            if (rc_q[i] + 10'd1 == RR) begin
                                rep_fire[i] = 1'b1;
                                rc_d[i]     = '0;
                            end else begin
                                rc_d[i] = rc_q[i] + 10'd1;
                            end
                        end
                    end
                    default: begin
                        rep_state_d[i] = IDLE;
                        rc_d[i]        = '0;
                    end
                endcase
            end
        end
        rep_pulse = {1'b0, rep_fire};
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            for (int unsigned i = 0; i < 2; i++) begin
                rep_state_q[i] <= IDLE;
            end
            rc_q <= '0;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                rep_state_q[i] <= rep_state_d[i];
            end
            rc_q <= rc_d;
        end
    end
`else
    assign rep_pulse = '0;
`endif

    assign btn_left     = stable_q[0];
    assign btn_right    = stable_q[1];
    assign btn_select   = stable_q[2];
    assign left_pulse   = pulse_q[0];
    assign right_pulse  = pulse_q[1];
    assign select_pulse = pulse_q[2];

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: reset, bounce, repeat, enable gating and active-low.
module tb_button_conditioner;

    logic clk = 1'b0;
    logic nRst = 1'b0;
    logic en = 1'b1;
    logic raw_left = 1'b0, raw_right = 1'b0, raw_select = 1'b0;
    logic btn_left, btn_right, btn_select, left_pulse, right_pulse, select_pulse;
    logic rb_left = 1'b1, rb_right = 1'b1, rb_select = 1'b1;
    logic bb_left, bb_right, bb_select, bp_left, bp_right, bp_select;

    always #5 clk = ~clk;

    button_conditioner #(
        .TICK_DIV(4), .DEBOUNCE_TICKS(3), .REPEAT_DELAY(5), .REPEAT_RATE(2), .ACTIVE_LOW(1'b0)
    ) u_dut (
        .clk(clk), .nRst(nRst), .en(en),
        .raw_left(raw_left), .raw_right(raw_right), .raw_select(raw_select),
        .btn_left(btn_left), .btn_right(btn_right), .btn_select(btn_select),
        .left_pulse(left_pulse), .right_pulse(right_pulse), .select_pulse(select_pulse)
    );

    button_conditioner #(
        .TICK_DIV(4), .DEBOUNCE_TICKS(3), .REPEAT_DELAY(5), .REPEAT_RATE(2), .ACTIVE_LOW(1'b1)
    ) u_dut_al (
        .clk(clk), .nRst(nRst), .en(en),
        .raw_left(rb_left), .raw_right(rb_right), .raw_select(rb_select),
        .btn_left(bb_left), .btn_right(bb_right), .btn_select(bb_select),
        .left_pulse(bp_left), .right_pulse(bp_right), .select_pulse(bp_select)
    );

    int checks = 0;
    int errors = 0;
    int k;
    int lp[$], rp[$], sp[$], blp[$], brp[$], bsp[$];
    int l_rise, r_rise, s_rise, l_fall, b_rise;
    int exp_q[$];

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_list(input string tag, input int got[$], input int exp[$]);
        check($sformatf("%s count", tag), got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            check($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
        end
    endtask

    // k = number of rising edges since reset release; sampled on the falling edge
    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            k++;
            if (left_pulse)   lp.push_back(k);
            if (right_pulse)  rp.push_back(k);
            if (select_pulse) sp.push_back(k);
            if (bp_left)      blp.push_back(k);
            if (bp_right)     brp.push_back(k);
            if (bp_select)    bsp.push_back(k);
            if (btn_left && l_rise < 0) l_rise = k;
            if (!btn_left && l_rise >= 0 && l_fall < 0) l_fall = k;
            if (btn_right && r_rise < 0) r_rise = k;
            if (btn_select && s_rise < 0) s_rise = k;
            if (bb_left && b_rise < 0) b_rise = k;
        end
    endtask

    task automatic do_reset(input logic l, input logic r, input logic s);
        @(negedge clk);
        nRst       = 1'b0;
        raw_left   = l;
        raw_right  = r;
        raw_select = s;
        rb_left    = 1'b1;
        rb_right   = 1'b1;
        rb_select  = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              int'({btn_left, btn_right, btn_select, left_pulse, right_pulse, select_pulse}), 0);
        check("reset_outputs_al",
              int'({bb_left, bb_right, bb_select, bp_left, bp_right, bp_select}), 0);
        lp.delete(); rp.delete(); sp.delete();
        blp.delete(); brp.delete(); bsp.delete();
        l_rise = -1; r_rise = -1; s_rise = -1; l_fall = -1; b_rise = -1;
        k = 0;
        nRst = 1'b1;
    endtask

    initial begin
        // Buttons held through reset: qualify on tick edges 4, 8, 12
        do_reset(1'b1, 1'b1, 1'b1);
        run(20);
        check("reset_l_rise", l_rise, 12);
        check("reset_r_rise", r_rise, 12);
        check("reset_s_rise", s_rise, 12);
        exp_q = '{12};
        check_list("reset_lp", lp, exp_q);
        check_list("reset_rp", rp, exp_q);
        check_list("reset_sp", sp, exp_q);

        // Select toggling every 5 cycles never sees 3 consecutive mismatching ticks
        do_reset(1'b0, 1'b0, 1'b0);
        for (int seg = 0; seg < 8; seg++) begin
            raw_select = (seg % 2 == 0);
            run(5);
        end
        raw_select = 1'b0;
        run(30);
        check("bounce_s_rise", s_rise, -1);
        check("bounce_sp_count", sp.size(), 0);

        // Left held 80 cycles: press at 12, released edge captured at 81, falls on tick 92
        do_reset(1'b0, 1'b0, 1'b0);
        raw_left = 1'b1;
        run(80);
        raw_left = 1'b0;
        run(40);
        check("rep_l_rise", l_rise, 12);
        check("rep_l_fall", l_fall, 92);
`ifdef BUTTON_AUTOREPEAT_EN
        exp_q = '{12, 32, 40, 48, 56, 64, 72, 80, 88};
`else
        exp_q = '{12};
`endif
        check_list("rep_lp", lp, exp_q);
        check("rep_rp_count", rp.size(), 0);

        // Press while disabled is ignored; tick counter resumes from 0 at edge 41
        en = 1'b0;
        do_reset(1'b0, 1'b0, 1'b0);
        raw_right = 1'b1;
        run(40);
        check("en_off_r_rise", r_rise, -1);
        check("en_off_rp_count", rp.size(), 0);
        en = 1'b1;
        run(20);
        check("en_on_r_rise", r_rise, 52);
        exp_q = '{52};
        check_list("en_on_rp", rp, exp_q);

        // Active-low instance: all three pins pulled low together
        do_reset(1'b0, 1'b0, 1'b0);
        rb_left   = 1'b0;
        rb_right  = 1'b0;
        rb_select = 1'b0;
        run(20);
        check("al_b_rise", b_rise, 12);
        exp_q = '{12};
        check_list("al_lp", blp, exp_q);
        check_list("al_rp", brp, exp_q);
        check_list("al_sp", bsp, exp_q);
        check("al_other_lp", lp.size() + rp.size() + sp.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
